// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-memory arbiter slice: line geometry
// and the burst FSM state encoding.
package cache_pkg;

  localparam int unsigned LINE_ADDR_LEN_DEF = 3;
  localparam int unsigned WORD_OFF_W        = LINE_ADDR_LEN_DEF;
  localparam int unsigned BYTE_OFF_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: when both request, the port not served last wins.
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory word port between the I-cache (port 0) and D-cache
// (port 1), running refills/writebacks as fixed-length word bursts.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter  int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter  int unsigned MEM_ADDR_W    = 32,
  localparam int unsigned LINE_WORDS    = 2 ** LINE_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    we0,
  input  logic [MEM_ADDR_W-1:0]   addr0,
  input  logic [32*LINE_WORDS-1:0] wdata0,
  output logic                    done0,
  input  logic                    req1,
  input  logic                    we1,
  input  logic [MEM_ADDR_W-1:0]   addr1,
  input  logic [32*LINE_WORDS-1:0] wdata1,
  output logic                    done1,
  output logic [32*LINE_WORDS-1:0] rdata,
  output logic                    busy,
  output logic                    grant,
  output logic                    mem_rd_req,
  output logic                    mem_wr_req,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready,
  output logic [31:0]             grant_cnt0,
  output logic [31:0]             grant_cnt1,
  output logic [31:0]             wait_cnt0,
  output logic [31:0]             wait_cnt1
);

  localparam int unsigned LINE_W = 32 * LINE_WORDS;
  localparam int unsigned OFF_LO = LINE_ADDR_LEN + BYTE_OFF_W;

  state_e                   state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] k_q, k_d;
  logic                     grant_q, grant_d;
  logic                     we_q, we_d;
  logic [MEM_ADDR_W-1:0]    base_q, base_d;
  logic [LINE_W-1:0]        wdata_q, wdata_d;
  logic [LINE_W-1:0]        rdata_q, rdata_d;
  logic [31:0]              gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;
  logic [31:0]              wcnt0_q, wcnt0_d, wcnt1_q, wcnt1_d;
  logic [1:0]               gnt;

  // grant_q doubles as the round-robin pointer; reset value 0 favours port 1
  arb_rr2 u_arb (
    .req_i  ({req1, req0}),
    .last_i (grant_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    grant_d    = grant_q;
    we_d       = we_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    gcnt0_d    = gcnt0_q;
    gcnt1_d    = gcnt1_q;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    done0      = 1'b0;
    done1      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          grant_d              = gnt[1];
          we_d                 = gnt[1] ? we1 : we0;
          base_d               = gnt[1] ? addr1 : addr0;
          base_d[OFF_LO-1:0]   = '0;
          wdata_d              = gnt[1] ? wdata1 : wdata0;
          k_d                  = '0;
          state_d              = ST_BURST;
        end
      end
      ST_BURST: begin
        mem_rd_req = ~we_q;
        mem_wr_req = we_q;
        mem_addr   = base_q + MEM_ADDR_W'({k_q, 2'b00});
        mem_wdata  = wdata_q[32*k_q +: 32];
        if (mem_ready) begin
          if (!we_q) begin
            rdata_d[32*k_q +: 32] = mem_rdata;
          end
          if (k_q == LINE_ADDR_LEN'(LINE_WORDS - 1)) begin
            state_d = ST_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done0   = ~grant_q;
        done1   = grant_q;
        gcnt0_d = gcnt0_q + {31'b0, ~grant_q};
        gcnt1_d = gcnt1_q + {31'b0, grant_q};
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    wcnt0_d = wcnt0_q + {31'b0, req0 & ~done0};
    wcnt1_d = wcnt1_q + {31'b0, req1 & ~done1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      wcnt0_q <= '0;
      wcnt1_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      wcnt0_q <= wcnt0_d;
      wcnt1_q <= wcnt1_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign grant      = grant_q;
  assign rdata      = rdata_q;
  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
  assign wait_cnt0  = wcnt0_q;
  assign wait_cnt1  = wcnt1_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: table of single-port bursts plus
// hand-timed sequences for contention, fairness and mid-burst reset.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, we0, req1, we1;
  logic [31:0]  addr0, addr1;
  logic [255:0] wdata0, wdata1;
  logic         done0, done1;
  logic [255:0] rdata;
  logic         busy, grant;
  logic         mem_rd_req, mem_wr_req;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_ready;
  logic [31:0]  grant_cnt0, grant_cnt1, wait_cnt0, wait_cnt1;

  always #5 clk = ~clk;

  // memory responder: each word's data is a fixed function of its address
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  cache_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .we0        (we0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .done0      (done0),
    .req1       (req1),
    .we1        (we1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .done1      (done1),
    .rdata      (rdata),
    .busy       (busy),
    .grant      (grant),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .wait_cnt0  (wait_cnt0),
    .wait_cnt1  (wait_cnt1)
  );

  typedef struct {
    bit           p;
    bit           we;
    logic [31:0]  addr;
    logic [31:0]  base;
    bit           alt;
    bit           scr;
    logic [255:0] wd;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] exp_rdata;
  logic [31:0]  exp_g0, exp_g1, exp_w0, exp_w1;
  int           order[$];
  vec_t         vecs[6];

  function automatic logic [31:0] resp(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [255:0] mkline(input logic [31:0] s);
    logic [255:0] l;
    for (int unsigned k = 0; k < 8; k++) l[32*k +: 32] = s + k;
    return l;
  endfunction

  function automatic logic [255:0] refline(input logic [31:0] base);
    logic [255:0] l;
    for (int unsigned k = 0; k < 8; k++) l[32*k +: 32] = resp(base + 4*k);
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state();
    for (int unsigned w = 0; w < 8; w++)
      chk($sformatf("rdata[%0d]", w), rdata[32*w +: 32], exp_rdata[32*w +: 32]);
    chk("grant_cnt0", grant_cnt0, exp_g0);
    chk("grant_cnt1", grant_cnt1, exp_g1);
    chk("wait_cnt0", wait_cnt0, exp_w0);
    chk("wait_cnt1", wait_cnt1, exp_w1);
  endtask

  task automatic set_port(input bit p, input bit r, input bit w,
                          input logic [31:0] a, input logic [255:0] d);
    if (p) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  // Called at a negedge while idle; returns at the first idle negedge after done.
  task automatic run_burst(input vec_t v);
    int c;
    int unsigned k;
    bit seen;
    int ncyc;
    ncyc = v.alt ? 16 : 8;
    c    = 0;
    seen = 0;
    set_port(v.p, 1'b1, v.we, v.addr, v.wd);
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if ((v.p ? done1 : done0) === 1'b1) begin
        seen = 1;
        chk("done_other", v.p ? done0 : done1, 0);
        chk("burst_cycles", c, ncyc);
        chk("grant_done", grant, v.p);
        set_port(v.p, 1'b0, 1'b0, 32'h0, '0);
        mem_ready = 1'b1;
      end else begin
        k = v.alt ? c / 2 : c;
        chk("busy", busy, 1);
        chk("grant", grant, v.p);
        chk("mem_rd_req", mem_rd_req, !v.we);
        chk("mem_wr_req", mem_wr_req, v.we);
        chk("mem_addr", mem_addr, v.base + 4*k);
        if (v.we) chk("mem_wdata", mem_wdata, v.wd[32*k +: 32]);
        if (!v.we && (!v.alt || (c % 2 == 1)))
          exp_rdata[32*k +: 32] = resp(v.base + 4*k);
        mem_ready = v.alt ? (c % 2 == 1) : 1'b1;
        if (v.scr && c == 3) set_port(v.p, 1'b1, !v.we, 32'hDEAD_BEEC, ~v.wd);
        c++;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done0_after", done0, 0);
    chk("done1_after", done1, 0);
    chk("busy_after", busy, 0);
    if (v.p) exp_g1++; else exp_g0++;
    if (v.p) exp_w1 += 1 + ncyc; else exp_w0 += 1 + ncyc;
    chk_state();
  endtask

  // Both ports raise refills together from a reset-fresh pointer: port 1 first.
  task automatic both_refill(input logic [31:0] a0, input logic [31:0] a1);
    logic        eb, eg, ed0, ed1;
    logic [31:0] base0, base1;
    base0 = a0 & 32'hFFFF_FFE0;
    base1 = a1 & 32'hFFFF_FFE0;
    mem_ready = 1'b1;
    set_port(1'b0, 1'b1, 1'b0, a0, mkline(32'h0));
    set_port(1'b1, 1'b1, 1'b0, a1, mkline(32'h0));
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      eb  = (n <= 9) || (n >= 11 && n <= 19);
      eg  = (n <= 10);
      ed0 = (n == 19);
      ed1 = (n == 9);
      chk($sformatf("both_busy@%0d", n), busy, eb);
      chk($sformatf("both_grant@%0d", n), grant, eg);
      chk($sformatf("both_done0@%0d", n), done0, ed0);
      chk($sformatf("both_done1@%0d", n), done1, ed1);
      if (n >= 1 && n <= 8) chk($sformatf("both_addr@%0d", n), mem_addr, base1 + 4*(n-1));
      if (n >= 11 && n <= 18) chk($sformatf("both_addr@%0d", n), mem_addr, base0 + 4*(n-11));
      if (n == 9) set_port(1'b1, 1'b0, 1'b0, 32'h0, '0);
      if (n == 19) set_port(1'b0, 1'b0, 1'b0, 32'h0, '0);
    end
    exp_rdata = refline(base0);
    exp_g0++; exp_g1++;
    exp_w0 += 19; exp_w1 += 9;
    chk_state();
  endtask

  task automatic request_once(input bit p, input logic [31:0] a);
    bit seen;
    seen = 0;
    set_port(p, 1'b1, 1'b0, a, '0);
    for (int n = 0; n < 80 && !seen; n++) begin
      @(negedge clk);
      if ((p ? done1 : done0) === 1'b1) begin
        seen = 1;
        order.push_back(int'(p));
        set_port(p, 1'b0, 1'b0, 32'h0, '0);
      end
    end
    if (!seen) chk("req_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dcount;
    rst = 1'b1; mem_ready = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    exp_rdata = '0; exp_g0 = 0; exp_g1 = 0; exp_w0 = 0; exp_w1 = 0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1024, 32'h0000_1020, 1'b0, 1'b0, mkline(32'h0)};
    vecs[1] = '{1'b0, 1'b1, 32'h2000_0047, 32'h2000_0040, 1'b1, 1'b0, mkline(32'h1000)};
    vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 1'b0, 1'b0, mkline(32'h0)};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_001C, 32'h0000_0000, 1'b1, 1'b0, mkline(32'hBEEF_0000)};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_4444, 32'h0000_4440, 1'b0, 1'b1, mkline(32'h7700)};
    vecs[5] = '{1'b0, 1'b0, 32'h8000_0020, 32'h8000_0020, 1'b1, 1'b0, mkline(32'h0)};

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_rd_req", mem_rd_req, 0);
    chk("rst_wr_req", mem_wr_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk_state();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    both_refill(32'h0000_0104, 32'h0000_021C);

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // fairness: port 0 re-raises after every done, port 1 asks once
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          request_once(1'b0, 32'h3000 + 32'h20 * i);
          if (i < 2) @(negedge clk);
        end
      end
      begin
        repeat (2) @(negedge clk);
        request_once(1'b1, 32'h5000);
      end
    join
    @(negedge clk);
    chk("order_len", order.size(), 4);
    if (order.size() == 4) begin
      chk("order[0]", order[0], 0);
      chk("order[1]", order[1], 1);
      chk("order[2]", order[2], 0);
      chk("order[3]", order[3], 0);
    end
    exp_rdata = refline(32'h3040);
    exp_g0 += 3; exp_g1 += 1;
    exp_w0 += 37; exp_w1 += 17;
    chk_state();

    // asynchronous reset in the middle of a port-0 refill
    set_port(1'b0, 1'b1, 1'b0, 32'h0000_0600, '0);
    repeat (4) @(negedge clk);
    chk("pre_rst_addr", mem_addr, 32'h0000_060C);
    rst = 1'b1;
    #1;
    set_port(1'b0, 1'b0, 1'b0, 32'h0, '0);
    exp_rdata = '0; exp_g0 = 0; exp_g1 = 0; exp_w0 = 0; exp_w1 = 0;
    chk("arst_busy", busy, 0);
    chk("arst_rd_req", mem_rd_req, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_grant", grant, 0);
    chk("arst_done0", done0, 0);
    chk_state();
    dcount = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n == 1) rst = 1'b0;
      if (done0 || done1 || busy) dcount++;
    end
    chk("no_done_after_rst", dcount, 0);

    both_refill(32'h0000_0700, 32'h0000_0800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
